// File: rtl/qr_fx_pkg.sv
// Shared definitions for the QR fixed-point datapath: Q-format constants,
// the operand-mode enum and saturation-limit helpers.
package qr_fx_pkg;

    localparam int QR_DATA_W = 16;
    localparam int QR_FRAC   = 14;

    typedef enum logic {
        TC_UNSIGNED = 1'b0,
        TC_SIGNED   = 1'b1
    } tc_mode_e;

    // Largest two's-complement value representable in w bits.
    function automatic logic signed [63:0] fx_smax(input int w);
        return (64'sd1 <<< (w - 1)) - 64'sd1;
    endfunction

    // Most negative two's-complement value representable in w bits.
    function automatic logic signed [63:0] fx_smin(input int w);
        return -(64'sd1 <<< (w - 1));
    endfunction

    // Largest unsigned value representable in w bits.
    function automatic logic signed [63:0] fx_umax(input int w);
        return (64'sd1 <<< w) - 64'sd1;
    endfunction

endpackage

// File: rtl/qr_fx_rescale.sv
// One-lane rescale: round-half-up by FRAC_SHIFT, then saturate to OUT_W
// using signed or unsigned limits depending on the beat's mode.
module qr_fx_rescale
    import qr_fx_pkg::*;
#(
    parameter int P_W        = 32,
    parameter int OUT_W      = 16,
    parameter int FRAC_SHIFT = 14
) (
    input  logic [P_W-1:0]   prod,
    input  tc_mode_e         tc,
    output logic [OUT_W-1:0] res,
    output logic             sat
);

    // One guard bit so the unsigned product plus rounding constant cannot wrap.
    localparam int EXT_W   = P_W + 1;
    localparam int RND_POS = (FRAC_SHIFT > 0) ? FRAC_SHIFT - 1 : 0;
    localparam logic [EXT_W-1:0] RND_ONE = {{(EXT_W-1){1'b0}}, 1'b1};
    localparam logic signed [EXT_W-1:0] RND = (FRAC_SHIFT > 0) ? (RND_ONE << RND_POS) : '0;

    localparam logic signed [63:0] S_MAX = fx_smax(OUT_W);
    localparam logic signed [63:0] S_MIN = fx_smin(OUT_W);
    localparam logic signed [63:0] U_MAX = fx_umax(OUT_W);

    logic signed [EXT_W-1:0] ext;
    logic signed [EXT_W-1:0] rnd;
    logic signed [EXT_W-1:0] shf;
    logic signed [63:0]      wide;
    logic signed [63:0]      lo;
    logic signed [63:0]      hi;

    // Extend, round, shift, then clamp to the output range of the active mode.
    always_comb begin
        // NOTE: every output gets a default before any branch, so no path can infer a latch.
        res  = '0;
        sat  = 1'b0;
        ext  = (tc == TC_SIGNED) ? {prod[P_W-1], prod} : {1'b0, prod};
        rnd  = ext + RND;
        shf  = (tc == TC_SIGNED) ? (rnd >>> FRAC_SHIFT) : (rnd >> FRAC_SHIFT);
        wide = {{(64-EXT_W){shf[EXT_W-1]}}, shf};
        lo   = (tc == TC_SIGNED) ? S_MIN : 64'sd0;
        hi   = (tc == TC_SIGNED) ? S_MAX : U_MAX;
        if (wide > hi) begin
            res = hi[OUT_W-1:0];
            sat = 1'b1;
        end else if (wide < lo) begin
            res = lo[OUT_W-1:0];
            sat = 1'b1;
        end else begin
            res = wide[OUT_W-1:0];
        end
    end

endmodule

// File: rtl/qr_mult_pipe_fx.sv
// Multi-lane pipelined fixed-point multiplier with valid/ready handshake,
// whole-pipeline stall, per-beat signed/unsigned mode, sideband tag and
// round+saturate rescale in the final stage.
module qr_mult_pipe_fx
    import qr_fx_pkg::*;
#(
    parameter int A_W        = QR_DATA_W,
    parameter int B_W        = QR_DATA_W,
    parameter int OUT_W      = QR_DATA_W,
    parameter int FRAC_SHIFT = QR_FRAC,
    parameter int LANES      = 2,
    parameter int STAGES     = 2,
    parameter int TAG_W      = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic                   in_tc,
    input  logic [LANES*A_W-1:0]   in_a,
    input  logic [LANES*B_W-1:0]   in_b,
    input  logic [TAG_W-1:0]       in_tag,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [LANES*OUT_W-1:0] out_data,
    output logic [TAG_W-1:0]       out_tag,
    output logic [LANES-1:0]       out_sat,
    output logic [LANES-1:0]       sat_sticky,
    input  logic                   sat_clr
);

    localparam int P_W = A_W + B_W;

    logic                   adv;
    tc_mode_e               in_mode;
    logic [LANES*P_W-1:0]   prod_in;

    logic                   fin_valid;
    tc_mode_e               fin_mode;
    logic [TAG_W-1:0]       fin_tag;
    logic [LANES*P_W-1:0]   fin_prod;

    logic [LANES*OUT_W-1:0] res_w;
    logic [LANES-1:0]       sat_w;

    // The whole pipe moves only when the output register is free or being drained.
    assign adv      = !(out_valid && !out_ready);
    assign in_ready = adv;
    assign in_mode  = tc_mode_e'(in_tc);

    // Full-width product of one lane, sign- or zero-extended by mode.
    function automatic logic [P_W-1:0] lane_mul(input logic [A_W-1:0] a,
                                                input logic [B_W-1:0] b,
                                                input tc_mode_e       tc);
        logic signed [P_W-1:0] sp;
        if (tc == TC_SIGNED) begin
            sp = P_W'($signed(a)) * P_W'($signed(b));
            return sp;
        end
        return P_W'(a) * P_W'(b);
    endfunction

    // Per-lane multiply of the incoming beat.
    always_comb begin
        prod_in = '0;
        for (int i = 0; i < LANES; i++) begin
            prod_in[i*P_W +: P_W] = lane_mul(in_a[i*A_W +: A_W], in_b[i*B_W +: B_W], in_mode);
        end
    end

    generate
        if (STAGES == 1) begin : g_direct
            assign fin_valid = in_valid;
            assign fin_mode  = in_mode;
            assign fin_tag   = in_tag;
            assign fin_prod  = prod_in;
        end else begin : g_pipe
            logic                 pv [STAGES-1];
            tc_mode_e             pm [STAGES-1];
            logic [TAG_W-1:0]     pt [STAGES-1];
            logic [LANES*P_W-1:0] pp [STAGES-1];

            // Product/sideband shift chain ahead of the rescale stage; bubbles are kept.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    for (int k = 0; k < STAGES - 1; k++) begin
                        pv[k] <= 1'b0;
                        pm[k] <= TC_UNSIGNED;
                        pt[k] <= '0;
                        pp[k] <= '0;
                    end
                end else if (adv) begin
                    // NOTE: non-blocking assignments make every stage sample pre-edge values, so the chain shifts exactly one place.
                    pv[0] <= in_valid;
                    pm[0] <= in_mode;
                    pt[0] <= in_tag;
                    pp[0] <= prod_in;
                    for (int k = 1; k < STAGES - 1; k++) begin
                        pv[k] <= pv[k-1];
                        pm[k] <= pm[k-1];
                        pt[k] <= pt[k-1];
                        pp[k] <= pp[k-1];
                    end
                end
            end

            assign fin_valid = pv[STAGES-2];
            assign fin_mode  = pm[STAGES-2];
            assign fin_tag   = pt[STAGES-2];
            assign fin_prod  = pp[STAGES-2];
        end
    endgenerate

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        qr_fx_rescale #(
            .P_W        (P_W),
            .OUT_W      (OUT_W),
            .FRAC_SHIFT (FRAC_SHIFT)
        ) u_rescale (
            .prod (fin_prod[i*P_W +: P_W]),
            .tc   (fin_mode),
            .res  (res_w[i*OUT_W +: OUT_W]),
            .sat  (sat_w[i])
        );
    end

    // Output register: loads the rescaled beat when the pipe advances, holds on stall.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_tag   <= '0;
            out_sat   <= '0;
        end else if (adv) begin
            out_valid <= fin_valid;
            out_data  <= res_w;
            out_tag   <= fin_tag;
            out_sat   <= fin_valid ? sat_w : '0;
        end
    end

    // Sticky saturation flags collect on output handshakes; a clear beats a same-cycle event.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sat_sticky <= '0;
        end else if (sat_clr) begin
            sat_sticky <= '0;
        end else if (out_valid && out_ready) begin
            sat_sticky <= sat_sticky | out_sat;
        end
    end

endmodule

// File: tb/tb_qr_mult_pipe_fx.sv
// Self-checking bench for qr_mult_pipe_fx: directed handshake/rescale cases on
// the default configuration, random traffic against a scoreboard, and a
// latency/exact-product sweep on STAGES=1 and STAGES=4 instances.
module tb_qr_mult_pipe_fx;

    typedef struct packed {
        logic [31:0] data;
        logic [3:0]  tag;
        logic [1:0]  sat;
    } exp_t;

    logic        clk;
    logic        rst;

    // Default instance
    logic        in_valid, in_ready, in_tc, out_valid, out_ready, sat_clr;
    logic [31:0] in_a, in_b, out_data;
    logic [3:0]  in_tag, out_tag;
    logic [1:0]  out_sat, sat_sticky;

    // Sweep instances (LANES=1, FRAC_SHIFT=0, OUT_W=32)
    logic        s1_in_valid, s1_in_ready, s1_in_tc, s1_out_valid, s1_out_ready, s1_sat_clr;
    logic [15:0] s1_in_a, s1_in_b;
    logic [31:0] s1_out_data;
    logic [3:0]  s1_in_tag, s1_out_tag;
    logic [0:0]  s1_out_sat, s1_sat_sticky;
    logic        s4_in_valid, s4_in_ready, s4_in_tc, s4_out_valid, s4_out_ready, s4_sat_clr;
    logic [15:0] s4_in_a, s4_in_b;
    logic [31:0] s4_out_data;
    logic [3:0]  s4_in_tag, s4_out_tag;
    logic [0:0]  s4_out_sat, s4_sat_sticky;

    int          checks;
    int          failures;
    exp_t        exp_q[$];
    logic [1:0]  sticky_m;

    // Loop/scratch state for the directed steps
    bit          acc, seen, found, ov, ordy, stc;
    int          sent, hold, lat;
    logic [31:0] hold_data, od, ra, rb;
    logic [3:0]  hold_tag, ot;
    logic [15:0] sa, sb;
    logic [0:0]  osat;
    longint      r;
    bit          s;

    qr_mult_pipe_fx dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_tc(in_tc),
        .in_a(in_a), .in_b(in_b), .in_tag(in_tag), .out_valid(out_valid),
        .out_ready(out_ready), .out_data(out_data), .out_tag(out_tag),
        .out_sat(out_sat), .sat_sticky(sat_sticky), .sat_clr(sat_clr)
    );

    qr_mult_pipe_fx #(.OUT_W(32), .FRAC_SHIFT(0), .LANES(1), .STAGES(1)) dut_s1 (
        .clk(clk), .rst(rst), .in_valid(s1_in_valid), .in_ready(s1_in_ready), .in_tc(s1_in_tc),
        .in_a(s1_in_a), .in_b(s1_in_b), .in_tag(s1_in_tag), .out_valid(s1_out_valid),
        .out_ready(s1_out_ready), .out_data(s1_out_data), .out_tag(s1_out_tag),
        .out_sat(s1_out_sat), .sat_sticky(s1_sat_sticky), .sat_clr(s1_sat_clr)
    );

    qr_mult_pipe_fx #(.OUT_W(32), .FRAC_SHIFT(0), .LANES(1), .STAGES(4)) dut_s4 (
        .clk(clk), .rst(rst), .in_valid(s4_in_valid), .in_ready(s4_in_ready), .in_tc(s4_in_tc),
        .in_a(s4_in_a), .in_b(s4_in_b), .in_tag(s4_in_tag), .out_valid(s4_out_valid),
        .out_ready(s4_out_ready), .out_data(s4_out_data), .out_tag(s4_out_tag),
        .out_sat(s4_out_sat), .sat_sticky(s4_sat_sticky), .sat_clr(s4_sat_clr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout required=finish");
        $fatal(1, "watchdog");
    end

    // Reference arithmetic: real-valued product, floor((p + half) / 2^fs), clamp.
    function automatic void lane_model(input longint a, input longint b, input bit tc,
                                       input int aw, input int bw, input int fs, input int ow,
                                       output longint res, output bit sat);
        longint one, pa, pb, p, lo, hi;
        one = 1;
        pa  = (tc && ((a >> (aw - 1)) & one) != 0) ? a - (one << aw) : a;
        pb  = (tc && ((b >> (bw - 1)) & one) != 0) ? b - (one << bw) : b;
        p   = pa * pb;
        if (fs > 0) p = p + (one << (fs - 1));
        p   = p >>> fs;
        lo  = tc ? -(one << (ow - 1)) : 0;
        hi  = tc ? (one << (ow - 1)) - 1 : (one << ow) - 1;
        sat = 1'b0;
        if (p > hi) begin p = hi; sat = 1'b1; end
        else if (p < lo) begin p = lo; sat = 1'b1; end
        res = p & ((one << ow) - 1);
    endfunction

    function automatic exp_t model_beat(input logic [31:0] a, input logic [31:0] b,
                                        input bit tc, input logic [3:0] tag);
        exp_t   e;
        longint lr;
        bit     ls;
        e.data = '0;
        e.sat  = '0;
        e.tag  = tag;
        for (int i = 0; i < 2; i++) begin
            lane_model(longint'(a[16*i +: 16]), longint'(b[16*i +: 16]), tc, 16, 16, 14, 16, lr, ls);
            e.data[16*i +: 16] = lr[15:0];
            e.sat[i] = ls;
        end
        return e;
    endfunction

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // One clock on the default instance, entered and left at a falling edge.
    task automatic tick(input bit v, input logic [31:0] a, input logic [31:0] b, input bit tc,
                        input logic [3:0] tag, input bit rdy, input bit clr, output bit accepted);
        exp_t e;
        bit   hs, popped;
        in_valid  = v;
        in_a      = a;
        in_b      = b;
        in_tc     = tc;
        in_tag    = tag;
        out_ready = rdy;
        sat_clr   = clr;
        popped    = 1'b0;
        e         = '0;
        #1;
        hs = out_valid && out_ready;
        chk("in_ready", 64'(in_ready), 64'(!(out_valid && !rdy)));
        if (hs) begin
            if (exp_q.size() == 0) begin
                chk("stale_beat", 64'(out_valid), 64'(0));
            end else begin
                e = exp_q.pop_front();
                popped = 1'b1;
                chk("out_data", 64'(out_data), 64'(e.data));
                chk("out_tag", 64'(out_tag), 64'(e.tag));
                chk("out_sat", 64'(out_sat), 64'(e.sat));
            end
        end
        accepted = v && in_ready;
        if (accepted) exp_q.push_back(model_beat(a, b, tc, tag));
        if (clr) sticky_m = '0;
        else if (popped) sticky_m = sticky_m | e.sat;
        @(negedge clk);
        chk("sat_sticky", 64'(sat_sticky), 64'(sticky_m));
    endtask

    task automatic idle(input bit rdy, input bit clr);
        bit dummy;
        tick(1'b0, '0, '0, 1'b0, '0, rdy, clr, dummy);
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        sticky_m = '0;
        rst = 1'b1;
        {in_valid, in_tc, sat_clr} = '0; out_ready = 1'b1;
        in_a = '0; in_b = '0; in_tag = '0;
        {s1_in_valid, s1_in_tc, s1_sat_clr, s4_in_valid, s4_in_tc, s4_sat_clr} = '0;
        s1_out_ready = 1'b1; s4_out_ready = 1'b1;
        s1_in_a = '0; s1_in_b = '0; s1_in_tag = '0;
        s4_in_a = '0; s4_in_b = '0; s4_in_tag = '0;

        // Reset state
        @(negedge clk); @(negedge clk);
        chk("rst_out_valid", 64'(out_valid), 64'(0));
        chk("rst_out_data", 64'(out_data), 64'(0));
        chk("rst_out_tag", 64'(out_tag), 64'(0));
        chk("rst_out_sat", 64'(out_sat), 64'(0));
        chk("rst_sat_sticky", 64'(sat_sticky), 64'(0));
        chk("rst_s1_valid", 64'(s1_out_valid), 64'(0));
        chk("rst_s4_valid", 64'(s4_out_valid), 64'(0));
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_in_ready", 64'(in_ready), 64'(1));

        // Basic signed: 1.0 * 0.5 in Q2.14, two-cycle latency
        tick(1'b1, {16'h4000, 16'h4000}, {16'h2000, 16'h2000}, 1'b1, 4'hA, 1'b1, 1'b0, acc);
        chk("basic_accept", 64'(acc), 64'(1));
        chk("basic_lat1", 64'(out_valid), 64'(0));
        idle(1'b1, 1'b0);
        chk("basic_lat2", 64'(out_valid), 64'(1));
        chk("basic_data", 64'(out_data), 64'h2000_2000);
        chk("basic_tag", 64'(out_tag), 64'hA);
        chk("basic_sat", 64'(out_sat), 64'(0));
        idle(1'b1, 1'b0);

        // Saturation on both lanes, sticky set, then cleared
        tick(1'b1, {16'h8000, 16'h7FFF}, {16'h8000, 16'h7FFF}, 1'b1, 4'h1, 1'b1, 1'b0, acc);
        idle(1'b1, 1'b0);
        chk("sat_data", 64'(out_data), 64'h7FFF_7FFF);
        chk("sat_flags", 64'(out_sat), 64'h3);
        idle(1'b1, 1'b0);
        chk("sat_sticky_set", 64'(sat_sticky), 64'h3);
        idle(1'b1, 1'b1);
        chk("sat_sticky_clr", 64'(sat_sticky), 64'h0);

        // Rounding ties toward +inf, and unsigned full-scale without clamp
        tick(1'b1, {16'hFFFF, 16'h0001}, {16'h2000, 16'h2000}, 1'b1, 4'h2, 1'b1, 1'b0, acc);
        tick(1'b1, {16'hFFFF, 16'hFFFF}, {16'h4000, 16'h4000}, 1'b0, 4'h3, 1'b1, 1'b0, acc);
        chk("round_data", 64'(out_data), 64'h0000_0001);
        chk("round_sat", 64'(out_sat), 64'h0);
        idle(1'b1, 1'b0);
        chk("unsigned_data", 64'(out_data), 64'hFFFF_FFFF);
        chk("unsigned_sat", 64'(out_sat), 64'h0);
        idle(1'b1, 1'b0);

        // Clear and a saturating handshake in the same cycle: clear wins
        tick(1'b1, {16'h7FFF, 16'h7FFF}, {16'h7FFF, 16'h7FFF}, 1'b1, 4'h4, 1'b1, 1'b0, acc);
        idle(1'b1, 1'b0);
        idle(1'b1, 1'b1);
        chk("clr_wins", 64'(sat_sticky), 64'h0);

        // Backpressure: 6 tagged beats, out_ready low 3 cycles after first out_valid
        sent = 0; hold = 0; seen = 1'b0;
        for (int c = 0; c < 40 && (sent < 6 || exp_q.size() > 0); c++) begin
            if (!seen && out_valid) begin
                seen = 1'b1; hold = 3; hold_data = out_data; hold_tag = out_tag;
            end
            ordy = (hold == 0);
            ra = $urandom; rb = $urandom; stc = 1'($urandom_range(0, 1));
            tick(sent < 6, ra, rb, stc, 4'(sent), ordy, 1'b0, acc);
            if (acc) sent++;
            if (hold > 0) begin
                hold--;
                chk("bp_in_ready", 64'(in_ready), 64'(0));
                chk("bp_data_stable", 64'(out_data), 64'(hold_data));
                chk("bp_tag_stable", 64'(out_tag), 64'(hold_tag));
            end
        end
        chk("bp_all_sent", 64'(sent), 64'(6));
        chk("bp_drained", 64'(exp_q.size()), 64'(0));

        // Reset mid-flight with a nonzero sticky and two beats in flight
        tick(1'b1, {16'h7FFF, 16'h8000}, {16'h7FFF, 16'h8000}, 1'b1, 4'h5, 1'b1, 1'b0, acc);
        idle(1'b1, 1'b0);
        idle(1'b1, 1'b0);
        chk("pre_rst_sticky", 64'(sat_sticky), 64'h3);
        tick(1'b1, 32'h1234_5678, 32'h0ABC_0DEF, 1'b1, 4'h6, 1'b1, 1'b0, acc);
        tick(1'b1, 32'h7000_7000, 32'h7000_7000, 1'b0, 4'h7, 1'b1, 1'b0, acc);
        in_valid = 1'b0;
        rst = 1'b1;
        #1;
        chk("midrst_out_valid", 64'(out_valid), 64'(0));
        chk("midrst_out_data", 64'(out_data), 64'(0));
        chk("midrst_out_sat", 64'(out_sat), 64'(0));
        chk("midrst_sticky", 64'(sat_sticky), 64'(0));
        exp_q.delete();
        sticky_m = '0;
        @(negedge clk); @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("midrst_in_ready", 64'(in_ready), 64'(1));
        for (int c = 0; c < 3; c++) begin
            idle(1'b1, 1'b0);
            chk("no_stale", 64'(out_valid), 64'(0));
        end
        tick(1'b1, 32'hC000_2000, 32'h2000_C000, 1'b1, 4'h9, 1'b1, 1'b0, acc);
        chk("post_rst_lat1", 64'(out_valid), 64'(0));
        idle(1'b1, 1'b0);
        chk("post_rst_lat2", 64'(out_valid), 64'(1));
        idle(1'b1, 1'b0);

        // Random traffic with random backpressure and occasional clears
        for (int c = 0; c < 40; c++) begin
            ra = $urandom; rb = $urandom; stc = 1'($urandom_range(0, 1));
            tick(1'($urandom_range(0, 1)), ra, rb, stc, 4'($urandom), $urandom_range(0, 3) != 0,
                 $urandom_range(0, 9) == 0, acc);
        end
        for (int c = 0; c < 20 && exp_q.size() > 0; c++) idle(1'b1, 1'b0);
        chk("rand_drained", 64'(exp_q.size()), 64'(0));

        // Sweep: exact full product, latency equal to STAGES
        for (int w = 0; w < 2; w++) begin
            for (int n = 0; n < 6; n++) begin
                sa = 16'($urandom); sb = 16'($urandom); stc = 1'($urandom_range(0, 1));
                if (n == 0) begin sa = 16'h8000; sb = 16'h8000; end
                if (n == 1) begin sa = 16'hFFFF; sb = 16'hFFFF; end
                lane_model(longint'(sa), longint'(sb), stc, 16, 16, 0, 32, r, s);
                if (w == 0) begin
                    s1_in_valid = 1'b1; s1_in_a = sa; s1_in_b = sb; s1_in_tc = stc; s1_in_tag = 4'(n);
                end else begin
                    s4_in_valid = 1'b1; s4_in_a = sa; s4_in_b = sb; s4_in_tc = stc; s4_in_tag = 4'(n);
                end
                @(negedge clk);
                s1_in_valid = 1'b0; s4_in_valid = 1'b0;
                found = 1'b0; lat = 0; od = '0; ot = '0; osat = '0;
                for (int k = 1; k <= 8 && !found; k++) begin
                    ov = (w == 0) ? s1_out_valid : s4_out_valid;
                    if (ov) begin
                        found = 1'b1; lat = k;
                        od   = (w == 0) ? s1_out_data : s4_out_data;
                        ot   = (w == 0) ? s1_out_tag : s4_out_tag;
                        osat = (w == 0) ? s1_out_sat : s4_out_sat;
                    end else begin
                        @(negedge clk);
                    end
                end
                chk("sweep_found", 64'(found), 64'(1));
                chk("sweep_latency", 64'(lat), 64'((w == 0) ? 1 : 4));
                chk("sweep_data", 64'(od), 64'(r[31:0]));
                chk("sweep_tag", 64'(ot), 64'(n));
                chk("sweep_sat", 64'(osat), 64'(s));
                @(negedge clk);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
